fpu_decode_issue: RTL and testbench

//  Decode/issue stage at the FPU front. Accepts a raw 32-bit Zhinx instruction plus three FP16

---
 rtl/fpu_decode_issue.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_decode_issue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_decode_issue.sv
// FP16 (Zhinx) decode/issue stage: decodes one instruction per cycle into a micro-op and
// issues it through a 2-entry skid buffer with valid/ready handshakes on both sides.
module fpu_decode_issue #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OPND_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic [2:0]        frm,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_instr,
    input  logic [OPND_W-1:0] in_rs1,
    input  logic [OPND_W-1:0] in_rs2,
    input  logic [OPND_W-1:0] in_rs3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_op,
    output logic [2:0]        out_rm,
    output logic [4:0]        out_rd,
    output logic [OPND_W-1:0] out_a,
    output logic [OPND_W-1:0] out_b,
    output logic [OPND_W-1:0] out_c,
    output logic              out_illegal
);

    // Buffer is built for exactly two entries; other DEPTH values are unsupported.
    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    localparam logic [6:0] OPC_OPFP   = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [4:0] F5_ADD   = 5'b00000;
    localparam logic [4:0] F5_SUB   = 5'b00001;
    localparam logic [4:0] F5_MUL   = 5'b00010;
    localparam logic [4:0] F5_DIV   = 5'b00011;
    localparam logic [4:0] F5_SGNJ  = 5'b00100;
    localparam logic [4:0] F5_MINMX = 5'b00101;
    localparam logic [4:0] F5_SQRT  = 5'b01011;
    localparam logic [4:0] F5_CMP   = 5'b10100;
    localparam logic [4:0] F5_CLASS = 5'b11100;

    localparam logic [1:0] FMT_HALF = 2'b10;
    localparam logic [2:0] RM_DYN   = 3'b111;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_MUL    = 5'd2;
    localparam logic [4:0] OP_DIV    = 5'd3;
    localparam logic [4:0] OP_SQRT   = 5'd4;
    localparam logic [4:0] OP_MIN    = 5'd5;
    localparam logic [4:0] OP_MAX    = 5'd6;
    localparam logic [4:0] OP_SGNJ   = 5'd7;
    localparam logic [4:0] OP_SGNJN  = 5'd8;
    localparam logic [4:0] OP_SGNJX  = 5'd9;
    localparam logic [4:0] OP_FLE    = 5'd10;
    localparam logic [4:0] OP_FLT    = 5'd11;
    localparam logic [4:0] OP_FEQ    = 5'd12;
    localparam logic [4:0] OP_CLASS  = 5'd13;
    localparam logic [4:0] OP_FMADD  = 5'd14;
    localparam logic [4:0] OP_FMSUB  = 5'd15;
    localparam logic [4:0] OP_FNMSUB = 5'd16;
    localparam logic [4:0] OP_FNMADD = 5'd17;

    typedef struct packed {
        logic [4:0]        op;
        logic [2:0]        rm;
        logic [4:0]        rd;
        logic              illegal;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [OPND_W-1:0] c;
    } uop_t;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] rm;
    logic [4:0] rs2;
    logic [1:0] fmt;
    logic [4:0] funct5;
    logic       unused_rs1_field;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rm     = in_instr[14:12];
    assign rs2    = in_instr[24:20];
    assign fmt    = in_instr[26:25];
    assign funct5 = in_instr[31:27];
    // Register indices are resolved upstream; operand values arrive on in_rs1/2/3.
    assign unused_rs1_field = ^in_instr[19:15];

    logic [4:0] op_dec;
    logic       rounding;
    logic       is_r4;
    logic       illegal;
    logic [2:0] rm_res;
    uop_t       uop_dec;

    always_comb begin
        op_dec   = OP_ADD;
        rounding = 1'b0;
        is_r4    = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_OPFP: begin
                case (funct5)
                    F5_ADD: begin op_dec = OP_ADD; rounding = 1'b1; end
                    F5_SUB: begin op_dec = OP_SUB; rounding = 1'b1; end
                    F5_MUL: begin op_dec = OP_MUL; rounding = 1'b1; end
                    F5_DIV: begin op_dec = OP_DIV; rounding = 1'b1; end
                    F5_SQRT: begin
                        op_dec   = OP_SQRT;
                        rounding = 1'b1;
                        if (rs2 != 5'd0) illegal = 1'b1;
                    end
                    F5_SGNJ: begin
                        case (rm)
                            3'b000:  op_dec = OP_SGNJ;
                            3'b001:  op_dec = OP_SGNJN;
                            3'b010:  op_dec = OP_SGNJX;
                            default: illegal = 1'b1;
                        endcase
                    end
                    F5_MINMX: begin
                        case (rm)
                            3'b000:  op_dec = OP_MIN;
                            3'b001:  op_dec = OP_MAX;
                            default: illegal = 1'b1;
                        endcase
                    end
                    F5_CMP: begin
                        case (rm)
                            3'b000:  op_dec = OP_FLE;
                            3'b001:  op_dec = OP_FLT;
                            3'b010:  op_dec = OP_FEQ;
                            default: illegal = 1'b1;
                        endcase
                    end
                    F5_CLASS: begin
                        op_dec = OP_CLASS;
                        if (rm != 3'b001 || rs2 != 5'd0) illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            // R4 forms: funct5 slot carries rs3, so only fmt/rm are validated.
            OPC_FMADD:  begin op_dec = OP_FMADD;  rounding = 1'b1; is_r4 = 1'b1; end
            OPC_FMSUB:  begin op_dec = OP_FMSUB;  rounding = 1'b1; is_r4 = 1'b1; end
            OPC_FNMSUB: begin op_dec = OP_FNMSUB; rounding = 1'b1; is_r4 = 1'b1; end
            OPC_FNMADD: begin op_dec = OP_FNMADD; rounding = 1'b1; is_r4 = 1'b1; end
            default:    illegal = 1'b1;
        endcase

        if (fmt != FMT_HALF) illegal = 1'b1;
        if (rounding) begin
            if (rm == 3'b101 || rm == 3'b110) illegal = 1'b1;
            if (rm == RM_DYN && frm > 3'b100) illegal = 1'b1;
        end

        rm_res = 3'b000;
        if (rounding) rm_res = (rm == RM_DYN) ? frm : rm;

        uop_dec.op      = illegal ? 5'd0 : op_dec;
        uop_dec.rm      = illegal ? 3'b000 : rm_res;
        uop_dec.rd      = rd;
        uop_dec.illegal = illegal;
        uop_dec.a       = illegal ? '0 : in_rs1;
        uop_dec.b       = illegal ? '0 : in_rs2;
        uop_dec.c       = (illegal || !is_r4) ? '0 : in_rs3;
    end

    uop_t       mem_q [2];
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       push, pop, wr_idx;

    assign in_ready  = (count_q < DEPTH_CNT);
    assign out_valid = (count_q != 2'd0);
    // A flushed cycle must not capture the incoming instruction.
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign wr_idx    = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01: begin
                    count_d = count_q - 2'd1;
                    head_d  = ~head_q;
                end
                2'b11:   head_d = ~head_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (push) mem_q[wr_idx] <= uop_dec;
        end
    end

    uop_t head_uop;
    assign head_uop = out_valid ? mem_q[head_q] : '0;

    assign out_op      = head_uop.op;
    assign out_rm      = head_uop.rm;
    assign out_rd      = head_uop.rd;
    assign out_illegal = head_uop.illegal;
    assign out_a       = head_uop.a;
    assign out_b       = head_uop.b;
    assign out_c       = head_uop.c;

endmodule

// File: tb/tb_fpu_decode_issue.sv
// Scoreboard bench for fpu_decode_issue: directed instructions push expected micro-ops,
// a negedge monitor pops and compares on every issue handshake.
module tb_fpu_decode_issue;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  rm;
        logic [4:0]  rd;
        logic        ill;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } uop_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  frm = 3'b000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [15:0] in_rs1 = 16'h0, in_rs2 = 16'h0, in_rs3 = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_op;
    logic [2:0]  out_rm;
    logic [4:0]  out_rd;
    logic [15:0] out_a, out_b, out_c;
    logic        out_illegal;

    fpu_decode_issue #(.WORD_W(32), .OPND_W(16), .DEPTH(2)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .frm(frm),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rm(out_rm),
        .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .out_illegal(out_illegal)
    );

    always #5 CLK = ~CLK;

    int    tests = 0;
    int    fails = 0;
    int    k = 0;
    uop_t  exp_q[$];
    string name_q[$];

    uop_t  got, snap, e;
    string nm;
    logic  stalled = 1'b0;

    always_comb got = {out_op, out_rm, out_rd, out_illegal, out_a, out_b, out_c};

    // Monitor: compares issued micro-ops and checks that stalled outputs hold.
    always @(negedge CLK) begin
        if (!nRST) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                tests++;
                if (got !== snap) begin
                    fails++;
                    $display("FAIL hold_stable: got %h required %h", got, snap);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_issue: got %h required no issue", got);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (got !== e) begin
                        fails++;
                        $display("FAIL %s: got %h required %h", nm, got, e);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            snap    = got;
        end
    end

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", n, act, req);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] fmt,
                                        input logic [4:0] rs2, input logic [2:0] rm,
                                        input logic [4:0] rd, input logic [6:0] opc);
        return {f5, fmt, rs2, 5'd1, rm, rd, opc};
    endfunction

    task automatic push(input string n, input logic [31:0] instr, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c, input logic [2:0] f,
                        input uop_t ex);
        int w;
        in_instr = instr; in_rs1 = a; in_rs2 = b; in_rs3 = c; frm = f; in_valid = 1'b1;
        w = 0;
        @(negedge CLK);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept_timeout: got in_ready=0 required 1", n);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        exp_q.push_back(ex);
        name_q.push_back(n);
        #1 in_valid = 1'b0;
    endtask

    // Builds the expected micro-op from hand-decoded op/rm; illegal zeroes op, rm, operands.
    task automatic chk(input string n, input logic [31:0] instr, input logic [2:0] f,
                       input logic [4:0] op, input logic [2:0] rm, input logic ill,
                       input logic r4);
        logic [15:0] a, b, c;
        uop_t ex;
        k++;
        a = 16'h3C00 + 16'(k); b = 16'h4400 + 16'(k); c = 16'h5800 + 16'(k);
        ex.op  = ill ? 5'd0 : op;
        ex.rm  = ill ? 3'd0 : rm;
        ex.rd  = instr[11:7];
        ex.ill = ill;
        ex.a   = ill ? 16'h0 : a;
        ex.b   = ill ? 16'h0 : b;
        ex.c   = (ill || !r4) ? 16'h0 : c;
        push(n, instr, a, b, c, f, ex);
    endtask

    task automatic do_flush(input string n);
        in_instr = enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd20, 7'h53);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge CLK);
        exp_q.delete();
        name_q.delete();
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge CLK);
        check({n, "_out_valid"}, 64'(out_valid), 64'd0);
        check({n, "_in_ready"}, 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(negedge CLK);
        out_ready = 1'b0;
    endtask

    initial begin
        uop_t ex;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_outputs", 64'(got), 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;

        ex = '{op: 5'd0, rm: 3'd0, rd: 5'd0, ill: 1'b0, a: 16'h3C00, b: 16'h4000, c: 16'h0};
        push("fadd_basic", 32'h04208053, 16'h3C00, 16'h4000, 16'h1234, 3'b000, ex);
        @(negedge CLK);
        check("fadd_latency_valid", 64'(out_valid), 64'd1);
        @(posedge CLK); #1;

        chk("fmul_dyn011", enc(5'd2, 2'b10, 5'd2, 3'b111, 5'd3, 7'h53), 3'b011, 5'd2, 3'b011, 0, 0);
        chk("fmul_dyn101", enc(5'd2, 2'b10, 5'd2, 3'b111, 5'd4, 7'h53), 3'b101, 5'd0, 3'b000, 1, 0);
        chk("fsub_dyn010", enc(5'd1, 2'b10, 5'd2, 3'b111, 5'd5, 7'h53), 3'b010, 5'd1, 3'b010, 0, 0);
        chk("fdiv_rm100", enc(5'd3, 2'b10, 5'd2, 3'b100, 5'd6, 7'h53), 3'b111, 5'd3, 3'b100, 0, 0);
        chk("fdiv_rm101", enc(5'd3, 2'b10, 5'd2, 3'b101, 5'd7, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fadd_single", enc(5'd0, 2'b00, 5'd2, 3'b000, 5'd8, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fclass_rs2", enc(5'd28, 2'b10, 5'd1, 3'b001, 5'd9, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fclass_ok", enc(5'd28, 2'b10, 5'd0, 3'b001, 5'd10, 7'h53), 3'b100, 5'd13, 3'b000, 0, 0);
        chk("fclass_rm0", enc(5'd28, 2'b10, 5'd0, 3'b000, 5'd11, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fmin", enc(5'd5, 2'b10, 5'd2, 3'b000, 5'd12, 7'h53), 3'b011, 5'd5, 3'b000, 0, 0);
        chk("fmax", enc(5'd5, 2'b10, 5'd2, 3'b001, 5'd13, 7'h53), 3'b000, 5'd6, 3'b000, 0, 0);
        chk("fminmax_rm2", enc(5'd5, 2'b10, 5'd2, 3'b010, 5'd14, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fsgnj", enc(5'd4, 2'b10, 5'd2, 3'b000, 5'd15, 7'h53), 3'b000, 5'd7, 3'b000, 0, 0);
        chk("fsgnjn", enc(5'd4, 2'b10, 5'd2, 3'b001, 5'd16, 7'h53), 3'b000, 5'd8, 3'b000, 0, 0);
        chk("fsgnjx", enc(5'd4, 2'b10, 5'd2, 3'b010, 5'd17, 7'h53), 3'b000, 5'd9, 3'b000, 0, 0);
        chk("fsgnj_rm3", enc(5'd4, 2'b10, 5'd2, 3'b011, 5'd18, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fle", enc(5'd20, 2'b10, 5'd2, 3'b000, 5'd19, 7'h53), 3'b000, 5'd10, 3'b000, 0, 0);
        chk("flt", enc(5'd20, 2'b10, 5'd2, 3'b001, 5'd20, 7'h53), 3'b000, 5'd11, 3'b000, 0, 0);
        chk("feq", enc(5'd20, 2'b10, 5'd2, 3'b010, 5'd21, 7'h53), 3'b000, 5'd12, 3'b000, 0, 0);
        chk("fcmp_rm3", enc(5'd20, 2'b10, 5'd2, 3'b011, 5'd22, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fsqrt", enc(5'd11, 2'b10, 5'd0, 3'b000, 5'd23, 7'h53), 3'b000, 5'd4, 3'b000, 0, 0);
        chk("fsqrt_rs2", enc(5'd11, 2'b10, 5'd1, 3'b000, 5'd24, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fsqrt_dyn100", enc(5'd11, 2'b10, 5'd0, 3'b111, 5'd25, 7'h53), 3'b100, 5'd4, 3'b100, 0, 0);
        chk("bad_opcode", enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd26, 7'h33), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("bad_funct5", enc(5'd8, 2'b10, 5'd2, 3'b000, 5'd27, 7'h53), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fmadd", enc(5'd5, 2'b10, 5'd2, 3'b001, 5'd28, 7'h43), 3'b000, 5'd14, 3'b001, 0, 1);
        chk("fmsub_dyn", enc(5'd6, 2'b10, 5'd2, 3'b111, 5'd29, 7'h47), 3'b000, 5'd15, 3'b000, 0, 1);
        chk("fnmsub", enc(5'd7, 2'b10, 5'd2, 3'b010, 5'd30, 7'h4B), 3'b000, 5'd16, 3'b010, 0, 1);
        chk("fnmadd", enc(5'd8, 2'b10, 5'd2, 3'b011, 5'd31, 7'h4F), 3'b000, 5'd17, 3'b011, 0, 1);
        chk("fmadd_fmt01", enc(5'd5, 2'b01, 5'd2, 3'b001, 5'd1, 7'h43), 3'b000, 5'd0, 3'b000, 1, 0);
        chk("fmadd_rm110", enc(5'd5, 2'b10, 5'd2, 3'b110, 5'd2, 7'h43), 3'b000, 5'd0, 3'b000, 1, 0);
        repeat (3) @(negedge CLK);

        // Back-pressure: two fill the buffer, third waits until execute drains one.
        out_ready = 1'b0;
        @(posedge CLK); #1;
        chk("stall_1", enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd1, 7'h53), 3'b000, 5'd0, 3'b000, 0, 0);
        chk("stall_2", enc(5'd1, 2'b10, 5'd2, 3'b001, 5'd2, 7'h53), 3'b000, 5'd1, 3'b001, 0, 0);
        fork
            chk("stall_3", enc(5'd2, 2'b10, 5'd2, 3'b010, 5'd3, 7'h53), 3'b000, 5'd2, 3'b010,
                0, 0);
            begin
                repeat (3) @(negedge CLK);
                check("stall_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge CLK); #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge CLK);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Flush with a full buffer, then with one entry and an acceptable input.
        out_ready = 1'b0;
        @(posedge CLK); #1;
        chk("flush_a", enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd4, 7'h53), 3'b000, 5'd0, 3'b000, 0, 0);
        chk("flush_b", enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd5, 7'h53), 3'b000, 5'd0, 3'b000, 0, 0);
        do_flush("flush_full");
        @(posedge CLK); #1;
        chk("flush_c", enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd6, 7'h53), 3'b000, 5'd0, 3'b000, 0, 0);
        do_flush("flush_one");

        // Asynchronous reset while stalled with a full buffer.
        @(posedge CLK); #1;
        chk("rst_a", enc(5'd5, 2'b10, 5'd2, 3'b001, 5'd7, 7'h43), 3'b000, 5'd14, 3'b001, 0, 1);
        chk("rst_b", enc(5'd2, 2'b10, 5'd2, 3'b000, 5'd8, 7'h53), 3'b000, 5'd2, 3'b000, 0, 0);
        #2 nRST = 1'b0;
        #1;
        check("midrst_outputs", 64'(got), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        name_q.delete();
        @(negedge CLK);
        #1 nRST = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge CLK);
        check("postrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge CLK); #1;
        chk("postrst_fadd", enc(5'd0, 2'b10, 5'd2, 3'b000, 5'd9, 7'h53), 3'b000, 5'd0, 3'b000,
            0, 0);
        repeat (3) @(negedge CLK);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

endmodule
